// File: rtl/controle_medicao_periodica.sv
// ---------------------------------------------------------------------------
// controle_medicao_periodica
//
// Periodic measurement scheduler placed in front of an HC-SR04 interface.
// Every PERIODO cycles it resets the interface, fires a one-cycle `medir`,
// then waits for `pronto_interface` or its own timeout. Accepted distances
// feed a 4-sample moving average. Three consecutive failures raise
// `erro_sensor`.
//
// Ports
//   clock              system clock, rising edge
//   reset              synchronous, active-high
//   ligar              enables periodic measurement
//   pronto_interface   measurement-done strobe from the interface
//   distancia_in       distance from the interface, valid with pronto
//   reset_interface    interface reset (high in PARADO and LIMPA)
//   medir              one-cycle start pulse to the interface
//   distancia_media    registered 4-sample moving average
//   media_valida       one-cycle pulse when the average covers 4 samples
//   amostras_validas   level, high once 4 samples have been accepted
//   erro_sensor        level, high after 3 consecutive failures
//   db_estado          state code for debug displays
// ---------------------------------------------------------------------------
module controle_medicao_periodica #(
    parameter int PERIODO        = 12_500_000,
    parameter int TIMEOUT_MEDIDA = 3_000_000,
    parameter int DIST_W         = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ligar,
    input  logic              pronto_interface,
    input  logic [DIST_W-1:0] distancia_in,
    output logic              reset_interface,
    output logic              medir,
    output logic [DIST_W-1:0] distancia_media,
    output logic              media_valida,
    output logic              amostras_validas,
    output logic              erro_sensor,
    output logic [3:0]        db_estado
);

    localparam int PER_W = $clog2(PERIODO + 1);
    localparam int TMO_W = $clog2(TIMEOUT_MEDIDA + 1);
    localparam int SOMA_W = DIST_W + 2;

    // State codes double as the debug display code.
    typedef enum logic [3:0] {
        PARADO         = 4'b0000,
        ESPERA_PERIODO = 4'b0001,
        LIMPA          = 4'b0010,
        DISPARA        = 4'b0011,
        AGUARDA        = 4'b0100,
        ACUMULA        = 4'b0101,
        MEDIA          = 4'b0110,
        FALHA          = 4'b0111
    } estado_t;

    estado_t estado_q, estado_d;

    logic [PER_W-1:0]              per_cnt_q, per_cnt_d;
    logic [TMO_W-1:0]              tmo_cnt_q, tmo_cnt_d;
    logic [DIST_W-1:0]             amostra_q, amostra_d;
    logic [3:0][DIST_W-1:0]        janela_q, janela_d;
    logic [SOMA_W-1:0]             soma_q, soma_d;
    logic [2:0]                    cont_q, cont_d;
    logic [1:0]                    falhas_q, falhas_d;
    logic                          erro_q, erro_d;
    logic [DIST_W-1:0]             media_q, media_d;

    logic fim_periodo;
    logic fim_timeout;
    logic acumula;

    // Each counter is held at zero outside its own state, so it is always
    // zero on entry. The terminal test uses N-1 so the state lasts exactly
    // N cycles.
    assign fim_periodo = (per_cnt_q == PER_W'(PERIODO - 1));
    assign fim_timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_MEDIDA - 1));
    assign acumula     = (estado_q == ACUMULA);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= PARADO;
            per_cnt_q <= '0;
            tmo_cnt_q <= '0;
            amostra_q <= '0;
            janela_q  <= '0;
            soma_q    <= '0;
            cont_q    <= '0;
            falhas_q  <= '0;
            erro_q    <= 1'b0;
            media_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            per_cnt_q <= per_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            amostra_q <= amostra_d;
            janela_q  <= janela_d;
            soma_q    <= soma_d;
            cont_q    <= cont_d;
            falhas_q  <= falhas_d;
            erro_q    <= erro_d;
            media_q   <= media_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            PARADO:         if (ligar) estado_d = ESPERA_PERIODO;
            ESPERA_PERIODO: begin
                if (!ligar)           estado_d = PARADO;
                else if (fim_periodo) estado_d = LIMPA;
            end
            LIMPA:          estado_d = DISPARA;
            DISPARA:        estado_d = AGUARDA;
            AGUARDA: begin
                // A reply on the last allowed cycle still counts as success.
                if (pronto_interface) estado_d = ACUMULA;
                else if (fim_timeout) estado_d = FALHA;
            end
            ACUMULA:        estado_d = MEDIA;
            MEDIA:          estado_d = ESPERA_PERIODO;
            FALHA:          estado_d = ESPERA_PERIODO;
            default:        estado_d = PARADO;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        reset_interface = 1'b0;
        medir           = 1'b0;
        db_estado       = 4'b1110;
        case (estado_q)
            PARADO:         begin reset_interface = 1'b1; db_estado = 4'b0000; end
            ESPERA_PERIODO: db_estado = 4'b0001;
            LIMPA:          begin reset_interface = 1'b1; db_estado = 4'b0010; end
            DISPARA:        begin medir = 1'b1; db_estado = 4'b0011; end
            AGUARDA:        db_estado = 4'b0100;
            ACUMULA:        db_estado = 4'b0101;
            MEDIA:          db_estado = 4'b0110;
            FALHA:          db_estado = 4'b0111;
            default:        db_estado = 4'b1110;
        endcase
    end

    assign media_valida     = (estado_q == MEDIA) && (cont_q == 3'd4);
    assign amostras_validas = (cont_q == 3'd4);
    assign erro_sensor      = erro_q;
    assign distancia_media  = media_q;

    // ------------------------------------------------------------- counters
    always_comb begin
        per_cnt_d = '0;
        tmo_cnt_d = '0;
        if (estado_q == ESPERA_PERIODO) per_cnt_d = per_cnt_q + PER_W'(1);
        if (estado_q == AGUARDA)        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    // ---------------------------------------------------- averaging window
    // Sample slot 0 takes the held reading; every other slot takes its
    // neighbour, so slot 3 always holds the oldest sample.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_janela
            logic [DIST_W-1:0] entrada;
            if (gi == 0) begin : g_primeira
                assign entrada = amostra_q;
            end else begin : g_demais
                assign entrada = janela_q[gi-1];
            end
            assign janela_d[gi] = acumula ? entrada : janela_q[gi];
        end
    endgenerate

    always_comb begin
        amostra_d = amostra_q;
        soma_d    = soma_q;
        cont_d    = cont_q;
        falhas_d  = falhas_q;
        erro_d    = erro_q;
        media_d   = media_q;

        if ((estado_q == AGUARDA) && pronto_interface)
            amostra_d = distancia_in;

        if (acumula) begin
            // Running sum: add newest, drop oldest. Empty slots are zero,
            // so the early averages are naturally scaled by 1/4.
            soma_d   = soma_q + {2'b00, amostra_q} - {2'b00, janela_q[3]};
            cont_d   = (cont_q == 3'd4) ? cont_q : cont_q + 3'd1;
            falhas_d = 2'd0;
            erro_d   = 1'b0;
            // Loaded on the ACUMULA edge so the new average is already
            // visible during MEDIA, together with media_valida.
            media_d  = soma_d[SOMA_W-1:2];
        end

        if (estado_q == FALHA) begin
            falhas_d = (falhas_q == 2'd3) ? falhas_q : falhas_q + 2'd1;
            if (falhas_d == 2'd3) erro_d = 1'b1;
        end
    end

endmodule
